// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encodings,
// funct3 access-size codes and the access legality rule.
package lsu_pkg;

   // FSM state encodings
   typedef logic [1:0] lsu_state_t;
   localparam lsu_state_t ST_IDLE = 2'd0;
   localparam lsu_state_t ST_REQ  = 2'd1;
   localparam lsu_state_t ST_DONE = 2'd2;

   // funct3 access size / signedness codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // An access is legal only when the size code exists for the operation
   // and the address is naturally aligned for that size.
   function automatic logic access_legal(input logic [2:0] f3,
                                         input logic [1:0] byte_off,
                                         input logic       is_store);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B:  ok = 1'b1;
         F3_H:  ok = (byte_off[0] == 1'b0);
         F3_W:  ok = (byte_off == 2'b00);
         F3_BU: ok = !is_store;
         F3_HU: ok = !is_store && (byte_off[0] == 1'b0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational data alignment for the LSU: store byte enables,
// store lane replication and load byte/half extraction with extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] store_lanes,
   output logic [31:0] load_value
);

   logic [31:0] byte_shifted;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Pick the addressed byte and half-word out of the read word
   always_comb begin
      byte_shifted = rdata >> {byte_off, 3'b000};
      sel_byte     = byte_shifted[7:0];
      sel_half     = byte_off[1] ? rdata[31:16] : rdata[15:0];
   end

   // Byte enables and replicated store data so any lane sees the value
   always_comb begin
      be          = 4'b0000;
      store_lanes = store_data;
      case (funct3)
         F3_B: begin
            be          = 4'b0001 << byte_off;
            store_lanes = {4{store_data[7:0]}};
         end
         F3_H: begin
            be          = 4'b0011 << byte_off;
            store_lanes = {2{store_data[15:0]}};
         end
         F3_W: begin
            be          = 4'b1111;
            store_lanes = store_data;
         end
         default: begin
            be          = 4'b0000;
            store_lanes = store_data;
         end
      endcase
   end

   // Extend the selected load value to a full register
   always_comb begin
      load_value = rdata;
      case (funct3)
         F3_B:    load_value = {{24{sel_byte[7]}}, sel_byte};
         F3_H:    load_value = {{16{sel_half[15]}}, sel_half};
         F3_W:    load_value = rdata;
         F3_BU:   load_value = {24'd0, sel_byte};
         F3_HU:   load_value = {16'd0, sel_half};
         default: load_value = rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core memory request at a time, issues a
// single word-aligned memory transaction and pulses done (with err for
// illegal or timed-out accesses).
// Optional feature: define LSU_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack
);

   lsu_state_t  state;
   logic [31:0] req_addr;
   logic [2:0]  req_f3;
   logic [31:0] req_wdata;
   logic        req_store;
   logic        err_pend;
   logic        new_req;
   logic        new_legal;
   logic [3:0]  be_steer;
   logic [31:0] wdata_steer;
   logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
   logic [15:0] timeout_cnt;
`else
   logic        unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Decode the incoming request; a simultaneous read+write is a store
   always_comb begin
      new_req   = mem_read || mem_write;
      new_legal = access_legal(funct3, addr[1:0], mem_write);
   end

   lsu_align u_align (
      .funct3      (req_f3),
      .byte_off    (req_addr[1:0]),
      .store_data  (req_wdata),
      .rdata       (dmem_rdata),
      .be          (be_steer),
      .store_lanes (wdata_steer),
      .load_value  (load_ext)
   );

   // Request FSM: latch in IDLE, hold the memory request in REQ, pulse in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         req_addr  <= 32'd0;
         req_f3    <= 3'd0;
         req_wdata <= 32'd0;
         req_store <= 1'b0;
         err_pend  <= 1'b0;
         load_data <= 32'd0;
`ifdef LSU_TIMEOUT_EN
         timeout_cnt <= 16'd0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (new_req) begin
                  req_addr  <= addr;
                  req_f3    <= funct3;
                  req_wdata <= wdata;
                  req_store <= mem_write;
                  err_pend  <= !new_legal;
                  state     <= new_legal ? ST_REQ : ST_DONE;
`ifdef LSU_TIMEOUT_EN
                  timeout_cnt <= 16'd0;
`endif
               end
            end
            ST_REQ: begin
               if (dmem_ack) begin
                  if (!req_store) begin
                     load_data <= load_ext;
                  end
                  err_pend <= 1'b0;
                  state    <= ST_DONE;
               end
`ifdef LSU_TIMEOUT_EN
               else if (timeout_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                  err_pend <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  timeout_cnt <= timeout_cnt + 16'd1;
               end
`endif
            end
            ST_DONE: begin
               err_pend <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               err_pend <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   // Core- and memory-facing outputs decoded from the current state
   always_comb begin
      stall      = ((state == ST_IDLE) && new_req) || (state == ST_REQ);
      done       = (state == ST_DONE);
      err        = (state == ST_DONE) && err_pend;
      dmem_req   = (state == ST_REQ);
      dmem_we    = (state == ST_REQ) && req_store;
      dmem_be    = ((state == ST_REQ) && req_store) ? be_steer : 4'b0000;
      dmem_addr  = {req_addr[31:2], 2'b00};
      dmem_wdata = wdata_steer;
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed corner cases plus randomized
// accesses compared against a behavioural memory-access model.
module tb_lsu;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic [31:0] load_data;
   logic        stall, done, err;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   int          n_compared   = 0;
   int          n_mismatched = 0;
   logic [31:0] model_load   = 32'd0;

   lsu #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .load_data  (load_data),
      .stall      (stall),
      .done       (done),
      .err        (err),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_be    (dmem_be),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Safety net against a hung run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference rules for legality, lanes and load extension
   function automatic bit ref_legal(input int f3, input int off, input bit st);
      if (f3 == 0) return 1;
      if (f3 == 1) return (off % 2) == 0;
      if (f3 == 2) return off == 0;
      if (f3 == 4) return !st;
      if (f3 == 5) return !st && (off % 2) == 0;
      return 0;
   endfunction

   function automatic logic [31:0] ref_be(input int f3, input int off);
      if (f3 == 0) return 32'(1 << off);
      if (f3 == 1) return 32'(3 << off);
      return 32'd15;
   endfunction

   function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] wd);
      if (f3 == 0) return (wd & 32'hFF) * 32'h0101_0101;
      if (f3 == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (off * 8)) & 32'hFF;
      h = (rd >> ((off / 2) * 16)) & 32'hFFFF;
      if (f3 == 0) return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      if (f3 == 1) return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      if (f3 == 4) return b;
      if (f3 == 5) return h;
      return rd;
   endfunction

   // Run one core access; the memory acks after 'delay' extra REQ cycles
   task automatic apply_stimulus(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdat, input int delay);
      bit st;
      bit legal;
      st    = wr;
      legal = ref_legal(int'(f3), int'(a[1:0]), st);
      @(negedge clk);
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      dmem_ack = 1'b0; dmem_rdata = rdat;
      #1;
      check_output("stall_seen", 32'(stall), 32'd1);
      check_output("done_idle", 32'(done), 32'd0);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      if (!legal) begin
         check_output("illegal_req", 32'(dmem_req), 32'd0);
         check_output("illegal_done", 32'(done), 32'd1);
         check_output("illegal_err", 32'(err), 32'd1);
         check_output("illegal_stall", 32'(stall), 32'd0);
         check_output("illegal_load", load_data, model_load);
      end else begin
         for (int i = 0; i <= delay; i++) begin
            check_output("req_held", 32'(dmem_req), 32'd1);
            check_output("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
            check_output("req_we", 32'(dmem_we), 32'(st));
            check_output("req_be", 32'(dmem_be), st ? ref_be(int'(f3), int'(a[1:0])) : 32'd0);
            if (st) check_output("req_wdata", dmem_wdata, ref_wdata(int'(f3), wd));
            check_output("req_stall", 32'(stall), 32'd1);
            check_output("req_done", 32'(done), 32'd0);
            if (i == delay) dmem_ack = 1'b1;
            @(negedge clk);
         end
         dmem_ack = 1'b0;
         if (!st) model_load = ref_load(int'(f3), int'(a[1:0]), rdat);
         check_output("ok_done", 32'(done), 32'd1);
         check_output("ok_err", 32'(err), 32'd0);
         check_output("ok_stall", 32'(stall), 32'd0);
         check_output("ok_req", 32'(dmem_req), 32'd0);
         check_output("ok_load", load_data, model_load);
      end
      @(negedge clk);
      check_output("done_pulse", 32'(done), 32'd0);
      check_output("err_pulse", 32'(err), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_stall"}, 32'(stall), 32'd0);
      check_output({tag, "_done"}, 32'(done), 32'd0);
      check_output({tag, "_err"}, 32'(err), 32'd0);
      check_output({tag, "_req"}, 32'(dmem_req), 32'd0);
      check_output({tag, "_we"}, 32'(dmem_we), 32'd0);
      check_output({tag, "_be"}, 32'(dmem_be), 32'd0);
      check_output({tag, "_addr"}, dmem_addr, 32'd0);
      check_output({tag, "_wdata"}, dmem_wdata, 32'd0);
      check_output({tag, "_load"}, load_data, 32'd0);
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
      addr = 32'd0; wdata = 32'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // Sign-extended byte load from the top lane, minimum latency
      apply_stimulus(1, 0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0);
      check_output("lb_value", load_data, 32'hFFFF_FF80);

      // Half store to the upper half, lanes replicated
      apply_stimulus(0, 1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'd0, 1);
      check_output("sh_keeps_load", load_data, 32'hFFFF_FF80);

      // Misaligned word load is rejected without a memory request
      apply_stimulus(1, 0, 3'b010, 32'h0000_0101, 32'd0, 32'h1234_5678, 0);
      check_output("lw_bad_keeps_load", load_data, 32'hFFFF_FF80);

      // Read and write together behave as a store
      apply_stimulus(1, 1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h1111_1111, 0);

`ifndef LSU_TIMEOUT_EN
      // Zero-extended half load with a slow memory
      apply_stimulus(1, 0, 3'b101, 32'h0000_0200, 32'd0, 32'hDEAD_8001, 4);
      check_output("lhu_value", load_data, 32'h0000_8001);
`endif

      // Randomized mix of loads and stores, legal and illegal
      for (int n = 0; n < 60; n++) begin
         int kind;
         bit r, w;
         kind = int'($urandom_range(0, 3));
         r = (kind != 1);
         w = (kind == 1) || (kind == 2);
         apply_stimulus(r, w, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                        int'($urandom_range(0, 3)));
      end

      // Reset during REQ drops the request and swallows the late ack
      @(negedge clk);
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300; dmem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      mem_read = 1'b0;
      check_output("rst_in_req", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      model_load = 32'd0;
      check_reset_values("rst_req");
      rst = 1'b0;
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      check_output("rst_no_done_a", 32'(done), 32'd0);
      @(negedge clk);
      check_output("rst_no_done_b", 32'(done), 32'd0);
      check_output("rst_load", load_data, 32'd0);

`ifdef LSU_TIMEOUT_EN
      // Unanswered request is abandoned after TO cycles with an error
      @(negedge clk);
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0400;
      @(negedge clk);
      mem_read = 1'b0;
      for (int i = 0; i < TO; i++) begin
         check_output("to_req_held", 32'(dmem_req), 32'd1);
         check_output("to_no_done", 32'(done), 32'd0);
         @(negedge clk);
      end
      check_output("to_req_drop", 32'(dmem_req), 32'd0);
      check_output("to_done", 32'(done), 32'd1);
      check_output("to_err", 32'(err), 32'd1);
      check_output("to_load", load_data, model_load);
      @(negedge clk);
      check_output("to_done_end", 32'(done), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: ack wait limit in cycles; used only when LSU_TIMEOUT_EN is defined.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 mem_read  input  1  load request from core.
REQ-005 mem_write  input  1  store request from core.
REQ-006 funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address (ALU result).
REQ-008 wdata  input  32  store data; low bits hold the B/H value.
REQ-009 load_data  output  32  aligned, extended load result feeding writeback select 01.
REQ-010 stall  output  1  core pipeline hold.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle error pulse, coincident with done.
REQ-013 dmem_req, dmem_we  output  1 each  memory request; write enable.
REQ-014 dmem_addr  output  32  word address; bits [1:0] always 0.
REQ-015 dmem_wdata  output  32  lane-steered store data.
REQ-016 dmem_be  output  4  byte enables; 0000 on reads.
REQ-017 dmem_rdata  input  32  read word.
REQ-018 dmem_ack  input  1  memory completion; valid only while dmem_req=1.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-020 IDLE: if mem_read or mem_write is high, the block SHALL latch addr, funct3, wdata and op type. It SHALL go to REQ if the access is legal, otherwise to DONE with err pending.
REQ-021 Illegal access SHALL mean: H/HU with addr[0]=1, W with addr[1:0]!=00, or funct3 011/110/111 (also 100/101 on a store); an illegal access SHALL issue no memory request.
REQ-022 mem_read and mem_write both high SHALL be treated as a store.
REQ-023 REQ: dmem_req SHALL stay 1, with addr/we/be/wdata stable, until dmem_ack=1; on ack the block SHALL capture load_data and go to DONE.
REQ-024 DONE: done=1 for exactly one cycle, stall=0, then return to IDLE; request inputs SHALL be ignored in DONE.
REQ-025 stall SHALL equal (IDLE and (mem_read or mem_write)) or REQ.
REQ-026 Minimum latency SHALL be: request seen in cycle N, dmem_req in N+1, ack in N+1, done in N+2.
REQ-027 Store byte enables: B gives 0001<<addr[1:0]; H gives 0011<<addr[1:0]; W gives 1111. wdata lanes SHALL be replicated (B to all 4 bytes, H to both halves).
REQ-028 Load extraction: select the byte/half by addr[1:0]; B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes the word through.
REQ-029 load_data SHALL hold its value until the next completed load; stores and errors SHALL leave it unchanged.

Reset
REQ-030 rst SHALL force IDLE, with stall, done, err, dmem_req, dmem_we = 0, dmem_be=0000, dmem_addr=0, dmem_wdata=0 and load_data=0.
REQ-031 rst asserted in REQ SHALL drop dmem_req on the next edge and discard any ack; no done pulse SHALL follow.

Configuration
REQ-032 With macro LSU_TIMEOUT_EN defined, an 8-bit+ counter SHALL count REQ cycles. Reaching TIMEOUT_CYCLES without ack SHALL drop dmem_req and go to DONE with err=1, leaving load_data unchanged.
REQ-033 Without LSU_TIMEOUT_EN there SHALL be no counter and REQ SHALL wait for ack indefinitely.

Structure
REQ-034 Package lsu_pkg SHALL hold the state enum and the funct3 size constants (B, H, W, BU, HU).
REQ-035 Sub-module lsu_align SHALL be purely combinational and hold the byte-enable generation, store lane steering and load extract/extend; the FSM SHALL stay in lsu.

Verification
REQ-036 LB at addr 0x103, rdata 0x80FF_1234, ack at 1st REQ cycle -> load_data 0xFFFF_FF80, done at cycle N+2.
REQ-037 SH at addr 0x102, wdata 0x0000_BEEF -> dmem_addr 0x100, be 1100, dmem_wdata 0xBEEF_BEEF, dmem_we=1.
REQ-038 LW at addr 0x101 -> no dmem_req, err=1 and done=1 at N+1, load_data unchanged.
REQ-039 LHU at 0x200, ack delayed 5 cycles -> stall high 6 cycles, load_data zero-extended, req held stable throughout.
REQ-040 rst pulsed in REQ, then ack -> IDLE, no done, outputs at reset values.
REQ-041 LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> req drops after 4 REQ cycles, err=1 and done=1.
